// File: rtl/sa_pkg.sv
// Shared systolic-array constants, FSM state encoding and the size helper.
package sa_pkg;

    localparam int LANES       = 16;
    localparam int DATA_WIDTH  = 8;
    localparam int INOUT_WIDTH = LANES * DATA_WIDTH;
    localparam int SIZE_WIDTH  = 5;
    localparam int CNT_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READ   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } sa_state_t;

    // A zero or oversized request means "all lanes".
    function automatic logic [SIZE_WIDTH-1:0] sa_eff_size(
        input logic [SIZE_WIDTH-1:0] sz,
        input int                    lanes
    );
        if (sz == '0 || int'(sz) > lanes) return SIZE_WIDTH'(lanes);
        return sz;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth delay line for one lane: data and valid travel together.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DEPTH = 0,
    parameter int DW    = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_data,
    input  logic          i_valid,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Lane 0 has no skew; clock and reset are intentionally unused here.
            logic w_unused;
            assign w_unused = clk ^ rst_n;
            assign o_data   = i_data;
            assign o_valid  = i_valid;
        end else begin : g_pipe
            logic [DEPTH-1:0][DW-1:0] r_data;
            logic [DEPTH-1:0]         r_valid;

            // Advance every stage by one slot per clock.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= '0;
                end else begin
                    r_data[0]  <= i_data;
                    r_valid[0] <= i_valid;
                    for (int s = 1; s < DEPTH; s++) begin
                        r_data[s]  <= r_data[s-1];
                        r_valid[s] <= r_valid[s-1];
                    end
                end
            end

            assign o_data  = r_data[DEPTH-1];
            assign o_valid = r_valid[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_input_feeder.sv
// Streams rows out of the DPRAM and skews them diagonally into the array.
module sa_input_feeder
    import sa_pkg::*;
#(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = sa_pkg::DATA_WIDTH,
    parameter int LANES       = sa_pkg::LANES,
    parameter int INOUT_WIDTH = LANES * DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [7:0]             num_rows,
    input  logic [4:0]             size,
    output logic                   re_a,
    output logic [ADDR_WIDTH-1:0]  addr_a,
    output logic [4:0]             size_a,
    input  logic [INOUT_WIDTH-1:0] dout_a,
    output logic [INOUT_WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   busy,
    output logic                   done
);

    sa_state_t                       r_state;
    sa_state_t                       w_next;
    logic [CNT_WIDTH-1:0]            r_cnt;
    logic [ADDR_WIDTH-1:0]           r_addr;
    logic [4:0]                      r_size;
    logic                            r_rd_vld;
    logic                            r_done;
    logic [4:0]                      w_start_size;

    logic [LANES-1:0][DATA_WIDTH-1:0] w_in_data;
    logic [LANES-1:0]                 w_in_vld;
    logic [LANES-1:0][DATA_WIDTH-1:0] w_lane_out;
    logic [LANES-1:0]                 w_lane_vld;

    assign w_start_size = sa_eff_size(size, LANES);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state: r_cnt holds rows still to read in READ, drain slots left in DRAIN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next = (num_rows == '0) ? ST_FINISH : ST_READ;
            ST_READ:   if (r_cnt == CNT_WIDTH'(1)) w_next = ST_DRAIN;
            ST_DRAIN:  if (r_cnt == '0) w_next = ST_FINISH;
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Transfer context: latched request, address accumulator and cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_size <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt  <= num_rows;
                        r_addr <= base_addr;
                        r_size <= w_start_size;
                    end
                end
                ST_READ: begin
                    r_addr <= r_addr + ADDR_WIDTH'(r_size);
                    r_cnt  <= (r_cnt == CNT_WIDTH'(1)) ? CNT_WIDTH'(LANES - 1)
                                                       : r_cnt - CNT_WIDTH'(1);
                end
                ST_DRAIN: r_cnt <= r_cnt - CNT_WIDTH'(1);
                default:  ;
            endcase
        end
    end

    // Read data lands one cycle after re_a; done is registered off FINISH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_vld <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_rd_vld <= (r_state == ST_READ);
            r_done   <= (r_state == ST_FINISH);
        end
    end

    assign busy   = (r_state != ST_IDLE);
    assign re_a   = (r_state == ST_READ);
    assign addr_a = re_a ? r_addr : '0;
    assign size_a = busy ? r_size : '0;
    assign done   = r_done;

    // Lane k gets byte k of the read word, delayed by k cycles.
    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            logic w_on;
            assign w_on         = r_rd_vld && (k < int'(r_size));
            assign w_in_vld[k]  = w_on;
            assign w_in_data[k] = w_on ? dout_a[k*DATA_WIDTH +: DATA_WIDTH] : '0;

            sa_skew_line #(
                .DEPTH (k),
                .DW    (DATA_WIDTH)
            ) u_skew (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_data  (w_in_data[k]),
                .i_valid (w_in_vld[k]),
                .o_data  (w_lane_out[k]),
                .o_valid (w_lane_vld[k])
            );
        end
    endgenerate

    assign data_out  = w_lane_out;
    assign valid_out = w_lane_vld;

endmodule

// File: tb/tb_sa_input_feeder.sv
// Bench for sa_input_feeder with a behavioural one-cycle DPRAM.
module tb_sa_input_feeder;
    import sa_pkg::*;

    localparam int AW        = 9;
    localparam int MEM_BYTES = 1 << AW;
    localparam int LN        = LANES;
    localparam int DW        = DATA_WIDTH;
    localparam int IW        = INOUT_WIDTH;
    localparam int NVEC      = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [7:0]    num_rows;
    logic [4:0]    size;
    logic          re_a;
    logic [AW-1:0] addr_a;
    logic [4:0]    size_a;
    logic [IW-1:0] dout_a = '0;
    logic [IW-1:0] data_out;
    logic [LN-1:0] valid_out;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    sa_input_feeder #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .LANES       (LN),
        .INOUT_WIDTH (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .size      (size),
        .re_a      (re_a),
        .addr_a    (addr_a),
        .size_a    (size_a),
        .dout_a    (dout_a),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // DPRAM: returns all lanes regardless of size so masking is exercised.
    logic [7:0] mem [MEM_BYTES];
    always @(posedge clk) begin
        if (re_a)
            for (int k = 0; k < LN; k++)
                dout_a[k*DW +: DW] <= mem[(int'(addr_a) + k) % MEM_BYTES];
    end

    task automatic check(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic          re;
        logic [AW-1:0] addr;
        logic [4:0]    sz;
        logic          busy;
        logic          done;
        logic [LN-1:0] vld;
        logic [IW-1:0] data;
    } exp_t;

    function automatic int eff_of(input int sz);
        return (sz == 0 || sz > LN) ? LN : sz;
    endfunction

    // Expected outputs at cycle c after the start cycle's successor (c=0 is the first busy cycle).
    function automatic exp_t model(input int c, input int base, input int n, input int eff);
        exp_t e;
        int   last_busy;
        last_busy = (n == 0) ? 0 : n + LN;
        e.re   = (c >= 0 && c < n);
        e.addr = AW'((base + c * eff) % MEM_BYTES);
        e.busy = (c >= 0 && c <= last_busy);
        e.sz   = e.busy ? 5'(eff) : 5'd0;
        e.done = (c == last_busy + 1);
        e.vld  = '0;
        e.data = '0;
        for (int k = 0; k < eff; k++) begin
            int i;
            i = c - 1 - k;
            if (i >= 0 && i < n) begin
                e.vld[k]           = 1'b1;
                e.data[k*DW +: DW] = mem[(base + i * eff + k) % MEM_BYTES];
            end
        end
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " re_a"},   IW'(re_a),      '0);
        check({tag, " addr_a"}, IW'(addr_a),    '0);
        check({tag, " size_a"}, IW'(size_a),    '0);
        check({tag, " busy"},   IW'(busy),      '0);
        check({tag, " done"},   IW'(done),      '0);
        check({tag, " valid"},  IW'(valid_out), '0);
        check({tag, " data"},   data_out,       '0);
    endtask

    // One transfer, checked cycle by cycle against the model; optional reset at cycle rst_at.
    task automatic run_xfer(input int base, input int n, input int sz, input bit noisy,
                            input int rst_at, output int done_lat, output int addr1,
                            output int nre, output int v15);
        int   eff;
        int   last;
        exp_t e;
        string tag;
        eff      = eff_of(sz);
        last     = (n == 0) ? 0 : n + LN;
        done_lat = -1;
        addr1    = -1;
        nre      = 0;
        v15      = -1;
        @(negedge clk);
        check("pre busy", IW'(busy), '0);
        start     = 1'b1;
        base_addr = AW'(base);
        num_rows  = 8'(n);
        size      = 5'(sz);
        for (int c = 0; c <= last + 2; c++) begin
            @(negedge clk);
            e   = model(c, base, n, eff);
            tag = $sformatf("b%0d n%0d s%0d c%0d", base, n, sz, c);
            check({tag, " re_a"},  IW'(re_a),      IW'(e.re));
            if (e.re) check({tag, " addr_a"}, IW'(addr_a), IW'(e.addr));
            check({tag, " size_a"}, IW'(size_a),   IW'(e.sz));
            check({tag, " busy"},  IW'(busy),      IW'(e.busy));
            check({tag, " done"},  IW'(done),      IW'(e.done));
            check({tag, " valid"}, IW'(valid_out), IW'(e.vld));
            check({tag, " data"},  data_out,       e.data);
            if (done && done_lat < 0) done_lat = c + 1;
            if (re_a) nre++;
            if (re_a && c == 1) addr1 = int'(addr_a);
            if (valid_out[LN-1]) v15 = c;
            if (c == rst_at) begin
                rst_n = 1'b0;
                start = 1'b0;
                @(negedge clk);
                check_all_zero({tag, " rst"});
                rst_n = 1'b1;
                break;
            end
            if (noisy && c <= last) begin
                start     = (c == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                base_addr = AW'($urandom);
                num_rows  = 8'($urandom);
                size      = 5'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        int base;
        int n;
        int sz;
        bit noisy;
        int exp_addr1;
        int exp_nre;
        int exp_v15;
        int exp_done;
    } vec_t;

    vec_t vt [NVEC];

    initial begin
        int done_lat, addr1, nre, v15;
        int base, n, sz, eff;
        bit noisy;

        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        num_rows  = '0;
        size      = '0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom_range(1, 255));
        for (int i = 16; i < 64; i++) mem[i] = 8'h11;

        // base, rows, size, noisy -> row-1 addr, re_a count, last lane-15 valid cycle, done latency from start
        vt[0] = '{16,  3, 16, 1'b0, 32,  3, 18, 21};
        vt[1] = '{48,  2,  8, 1'b0, 56,  2, -1, 20};
        vt[2] = '{100, 0, 16, 1'b0, -1,  0, -1,  2};
        vt[3] = '{504, 2, 16, 1'b0,  8,  2, 17, 20};
        vt[4] = '{16,  3, 16, 1'b1, 32,  3, 18, 21};
        vt[5] = '{200, 2,  0, 1'b0, 216, 2, 17, 20};
        vt[6] = '{40,  1, 20, 1'b0, -1,  1, 16, 19};
        vt[7] = '{300, 4,  1, 1'b0, 301, 4, -1, 22};
        vt[8] = '{10,  0,  5, 1'b1, -1,  0, -1,  2};

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int t = 0; t < NVEC; t++) begin
            run_xfer(vt[t].base, vt[t].n, vt[t].sz, vt[t].noisy, -1, done_lat, addr1, nre, v15);
            check_int($sformatf("vec%0d addr1", t),    addr1,    vt[t].exp_addr1);
            check_int($sformatf("vec%0d re_count", t), nre,      vt[t].exp_nre);
            check_int($sformatf("vec%0d lane15", t),   v15,      vt[t].exp_v15);
            check_int($sformatf("vec%0d done", t),     done_lat, vt[t].exp_done);
        end

        // Reset in the middle of DRAIN: no done afterwards, then a clean transfer.
        run_xfer(16, 3, 16, 1'b0, 6, done_lat, addr1, nre, v15);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            check($sformatf("post-rst c%0d done", c), IW'(done), '0);
            check($sformatf("post-rst c%0d busy", c), IW'(busy), '0);
        end
        run_xfer(16, 3, 16, 1'b0, -1, done_lat, addr1, nre, v15);
        check_int("after-rst done", done_lat, 21);
        check_int("after-rst addr1", addr1, 32);

        // Randomized transfers over fresh memory contents.
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom_range(1, 255));
        for (int t = 0; t < 25; t++) begin
            base  = int'($urandom_range(0, MEM_BYTES - 1));
            n     = int'($urandom_range(0, 6));
            sz    = int'($urandom_range(0, 31));
            noisy = 1'($urandom_range(0, 1));
            eff   = eff_of(sz);
            run_xfer(base, n, sz, noisy, -1, done_lat, addr1, nre, v15);
            check_int($sformatf("rnd%0d re_count", t), nre, n);
            check_int($sformatf("rnd%0d done", t), done_lat, (n == 0) ? 2 : n + LN + 2);
            check_int($sformatf("rnd%0d addr1", t), addr1, (n >= 2) ? (base + eff) % MEM_BYTES : -1);
            check_int($sformatf("rnd%0d lane15", t), v15, (eff == LN && n > 0) ? n + LN - 1 : -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
